// File: rtl/rv_wb_pkg.sv
// Shared types and helpers for the register-file write-back front end:
// load funct3 encodings, the buffered write entry, and load data extension.
package rv_wb_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Picks the addressed byte/half out of the aligned word and extends it;
  // any funct3 that is not a byte or half load behaves like LW.
  function automatic logic [XLEN-1:0] load_extend(
    input logic [XLEN-1:0] data,
    input logic [2:0]      funct3,
    input logic [1:0]      boff
  );
    logic [7:0]      byte_val;
    logic [15:0]     half_val;
    logic [XLEN-1:0] result;
    byte_val = data[{boff, 3'b000} +: 8];
    half_val = data[{boff[1], 4'b0000} +: 16];
    case (funct3)
      LB:      result = {{(XLEN-8){byte_val[7]}}, byte_val};
      LH:      result = {{(XLEN-16){half_val[15]}}, half_val};
      LBU:     result = {{(XLEN-8){1'b0}}, byte_val};
      LHU:     result = {{(XLEN-16){1'b0}}, half_val};
      default: result = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small synchronous FIFO holding extended load responses until the single
// register-file write port is free.
module wb_load_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU results and buffered load responses onto the single register-file
// write port, and tracks which registers still wait on a load.
module regfile_writeback
  import rv_wb_pkg::*;
#(
  parameter int XLEN           = rv_wb_pkg::XLEN,
  parameter int LSU_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [4:0]      i_lsu_rd,
  input  logic [XLEN-1:0] i_lsu_data,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [1:0]      i_lsu_boff,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  output logic [31:0]     o_busy,
  output logic            o_wb_stall,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t       push_entry;
  wb_entry_t       head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;
  logic [SW-1:0]   starve_cnt;

  assign o_lsu_ready     = !fifo_full;
  assign push            = i_lsu_valid && !fifo_full;
  assign push_entry.rd   = i_lsu_rd;
  assign push_entry.data = load_extend(i_lsu_data, i_lsu_funct3, i_lsu_boff);

  wb_load_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // The ALU has no backpressure, so it always wins; loads fill idle slots.
  always_comb begin
    pop       = 1'b0;
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (i_alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = i_alu_rd;
      sel_data  = i_alu_data;
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = head.rd;
      sel_data  = head.data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wren <= sel_valid && (sel_rd != 5'd0);
      o_rd_addr <= sel_rd;
      o_rd_data <= sel_data;
    end
  end

  // A new issue to the same register outranks the completing load.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (i_issue_valid)
      set_mask[i_issue_rd] = 1'b1;
    if (pop)
      clr_mask[head.rd] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      o_busy <= '0;
    else
      o_busy <= ((o_busy & ~clr_mask) | set_mask) & ~32'd1;
  end

  // Counts consecutive cycles a waiting load lost the port; saturates at the limit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      starve_cnt <= '0;
    else if (fifo_empty || pop)
      starve_cnt <= '0;
    else if (i_alu_valid && (starve_cnt != SW'(STARVE_LIMIT)))
      starve_cnt <= starve_cnt + SW'(1);
  end

  assign o_wb_stall = (starve_cnt >= SW'(STARVE_LIMIT));

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomised and directed bench for regfile_writeback: a queue-based reference
// model predicts every cycle's outputs, and a negedge monitor compares them.
module tb_regfile_writeback;
  import rv_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_data;
  logic [2:0]  i_lsu_funct3;
  logic [1:0]  i_lsu_boff;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic [31:0] o_busy;
  logic        o_wb_stall;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;

  always #5 i_clk = ~i_clk;

  regfile_writeback #(
    .XLEN           (32),
    .LSU_FIFO_DEPTH (DEPTH),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_alu_valid   (i_alu_valid),
    .i_alu_rd      (i_alu_rd),
    .i_alu_data    (i_alu_data),
    .i_lsu_valid   (i_lsu_valid),
    .o_lsu_ready   (o_lsu_ready),
    .i_lsu_rd      (i_lsu_rd),
    .i_lsu_data    (i_lsu_data),
    .i_lsu_funct3  (i_lsu_funct3),
    .i_lsu_boff    (i_lsu_boff),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .o_busy        (o_busy),
    .o_wb_stall    (o_wb_stall),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_rd_wren     (o_rd_wren)
  );

  typedef struct {
    bit          alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    bit          lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [2:0]  f3;
    logic [1:0]  boff;
    bit          iss_v;
    logic [4:0]  iss_rd;
  } stim_t;

  typedef struct {
    bit          wren;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] busy;
    bit          ready;
    bit          stall;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  exp_t  exp_q[$];
  ld_t   model_fifo[$];
  bit    model_busy[32];
  int    model_lost = 0;
  int    total = 0;
  int    bad = 0;
  exp_t  mon_e;
  stim_t s;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Load extension from the ISA rules using plain integer arithmetic.
  function automatic logic [31:0] ref_extend(input logic [31:0] data, input logic [2:0] f3,
                                             input logic [1:0] boff);
    longint b, h, v;
    b = longint'((data >> (8 * boff)) & 32'hFF);
    h = longint'((data >> (16 * (boff / 2))) & 32'hFFFF);
    case (f3)
      3'd0:    v = (b >= 128) ? b - 256 : b;
      3'd1:    v = (h >= 32768) ? h - 65536 : h;
      3'd4:    v = b;
      3'd5:    v = h;
      default: v = longint'(data);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = model_busy[i];
    return v;
  endfunction

  function automatic stim_t idle_s();
    stim_t t;
    t = '{default: 0};
    return t;
  endfunction

  function automatic stim_t alu_s(input logic [4:0] rd, input logic [31:0] data);
    stim_t t;
    t = idle_s();
    t.alu_v = 1; t.alu_rd = rd; t.alu_data = data;
    return t;
  endfunction

  function automatic stim_t lsu_s(input logic [4:0] rd, input logic [31:0] data,
                                  input logic [2:0] f3, input logic [1:0] boff);
    stim_t t;
    t = idle_s();
    t.lsu_v = 1; t.lsu_rd = rd; t.lsu_data = data; t.f3 = f3; t.boff = boff;
    return t;
  endfunction

  // Drives one cycle, advances the reference model across the edge and queues
  // what the DUT must show afterwards. Honours the pipeline's stall promise.
  task automatic applyStimulus(input stim_t st);
    exp_t e;
    ld_t  popped;
    bit   did_pop;
    bit   hs;
    int   size_pre;
    if (model_lost >= LIMIT) st.alu_v = 0;
    i_alu_valid   = st.alu_v;
    i_alu_rd      = st.alu_rd;
    i_alu_data    = st.alu_data;
    i_lsu_valid   = st.lsu_v;
    i_lsu_rd      = st.lsu_rd;
    i_lsu_data    = st.lsu_data;
    i_lsu_funct3  = st.f3;
    i_lsu_boff    = st.boff;
    i_issue_valid = st.iss_v;
    i_issue_rd    = st.iss_rd;
    @(posedge i_clk);
    size_pre = model_fifo.size();
    hs       = st.lsu_v && (size_pre < DEPTH);
    did_pop  = !st.alu_v && (size_pre > 0);
    popped   = '{rd: 5'd0, data: 32'd0};
    if (did_pop) popped = model_fifo.pop_front();
    if (size_pre == 0 || did_pop) model_lost = 0;
    else if (st.alu_v) model_lost++;
    e.wren = 0; e.addr = '0; e.data = '0;
    if (st.alu_v) begin
      e.addr = st.alu_rd; e.data = st.alu_data; e.wren = (st.alu_rd != 0);
    end else if (did_pop) begin
      e.addr = popped.rd; e.data = popped.data; e.wren = (popped.rd != 0);
    end
    if (did_pop) model_busy[popped.rd] = 0;
    if (st.iss_v) model_busy[st.iss_rd] = 1;
    model_busy[0] = 0;
    if (hs) model_fifo.push_back('{rd: st.lsu_rd, data: ref_extend(st.lsu_data, st.f3, st.boff)});
    e.busy  = busy_vec();
    e.ready = (model_fifo.size() < DEPTH);
    e.stall = (model_lost >= LIMIT);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic pulseReset();
    #1;
    i_reset = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("rst_wren", 32'(o_rd_wren), 32'd0);
    checkOutput("rst_busy", o_busy, 32'd0);
    checkOutput("rst_ready", 32'(o_lsu_ready), 32'd1);
    s = idle_s();
    i_alu_valid = 0; i_lsu_valid = 0; i_issue_valid = 0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    model_fifo.delete();
    for (int i = 0; i < 32; i++) model_busy[i] = 0;
    model_lost = 0;
  endtask

  always @(negedge i_clk) begin
    if (!i_reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("wren", 32'(o_rd_wren), 32'(mon_e.wren));
      if (mon_e.wren) begin
        checkOutput("addr", 32'(o_rd_addr), 32'(mon_e.addr));
        checkOutput("data", o_rd_data, mon_e.data);
      end
      checkOutput("busy", o_busy, mon_e.busy);
      checkOutput("ready", 32'(o_lsu_ready), 32'(mon_e.ready));
      checkOutput("stall", 32'(o_wb_stall), 32'(mon_e.stall));
    end
  end

  initial begin
    i_reset = 1'b1;
    i_alu_valid = 0; i_alu_rd = '0; i_alu_data = '0;
    i_lsu_valid = 0; i_lsu_rd = '0; i_lsu_data = '0; i_lsu_funct3 = '0; i_lsu_boff = '0;
    i_issue_valid = 0; i_issue_rd = '0;
    for (int i = 0; i < 32; i++) model_busy[i] = 0;
    #12;
    i_reset = 1'b0;
    #1;
    checkOutput("init_wren", 32'(o_rd_wren), 32'd0);
    checkOutput("init_addr", 32'(o_rd_addr), 32'd0);
    checkOutput("init_data", o_rd_data, 32'd0);
    checkOutput("init_busy", o_busy, 32'd0);
    checkOutput("init_ready", 32'(o_lsu_ready), 32'd1);
    checkOutput("init_stall", 32'(o_wb_stall), 32'd0);

    // ALU write lands one cycle later.
    applyStimulus(alu_s(5'd5, 32'h1234));
    checkOutput("alu_wren", 32'(o_rd_wren), 32'd1);
    checkOutput("alu_addr", 32'(o_rd_addr), 32'd5);
    checkOutput("alu_data", o_rd_data, 32'h0000_1234);

    // Load extension cases.
    applyStimulus(lsu_s(5'd3, 32'h0000_8000, LB, 2'd1));
    applyStimulus(idle_s());
    checkOutput("lb_data", o_rd_data, 32'hFFFF_FF80);
    applyStimulus(lsu_s(5'd3, 32'h0000_8000, LBU, 2'd1));
    applyStimulus(idle_s());
    checkOutput("lbu_data", o_rd_data, 32'h0000_0080);
    applyStimulus(lsu_s(5'd3, 32'h8001_0000, LH, 2'd2));
    applyStimulus(idle_s());
    checkOutput("lh_data", o_rd_data, 32'hFFFF_8001);

    // Fill the FIFO while the ALU hogs the port, then let it starve into a stall.
    for (int i = 0; i < 4; i++) begin
      s = lsu_s(5'(10 + i), 32'hA000_0000 + 32'(i), LW, 2'd0);
      s.alu_v = 1; s.alu_rd = 5'd9; s.alu_data = 32'(i);
      applyStimulus(s);
    end
    checkOutput("full_ready", 32'(o_lsu_ready), 32'd0);
    checkOutput("starve_stall", 32'(o_wb_stall), 32'd1);
    applyStimulus(idle_s());
    checkOutput("starve_wren", 32'(o_rd_wren), 32'd1);
    checkOutput("starve_addr", 32'(o_rd_addr), 32'd10);
    checkOutput("starve_ready", 32'(o_lsu_ready), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(idle_s());

    // Scoreboard set, clear on writeback, and set-wins on same-cycle re-issue.
    s = idle_s(); s.iss_v = 1; s.iss_rd = 5'd7;
    applyStimulus(s);
    checkOutput("busy7_set", 32'(o_busy[7]), 32'd1);
    applyStimulus(lsu_s(5'd7, 32'h7777_7777, LW, 2'd0));
    applyStimulus(idle_s());
    checkOutput("busy7_wren", 32'(o_rd_wren), 32'd1);
    checkOutput("busy7_clr", 32'(o_busy[7]), 32'd0);
    applyStimulus(lsu_s(5'd7, 32'h1111_2222, LW, 2'd0));
    s = idle_s(); s.iss_v = 1; s.iss_rd = 5'd7;
    applyStimulus(s);
    checkOutput("busy7_rewren", 32'(o_rd_wren), 32'd1);
    checkOutput("busy7_setwins", 32'(o_busy[7]), 32'd1);

    // Writes to x0 are consumed silently.
    applyStimulus(alu_s(5'd0, 32'hFFFF_FFFF));
    checkOutput("x0_alu_wren", 32'(o_rd_wren), 32'd0);
    applyStimulus(lsu_s(5'd0, 32'hDEAD_BEEF, LW, 2'd0));
    applyStimulus(idle_s());
    checkOutput("x0_lsu_wren", 32'(o_rd_wren), 32'd0);
    checkOutput("x0_busy0", 32'(o_busy[0]), 32'd0);
    checkOutput("x0_drained", 32'(o_lsu_ready), 32'd1);

    // Mid-operation reset with two loads buffered.
    s = lsu_s(5'd20, 32'h2020_2020, LW, 2'd0);
    s.alu_v = 1; s.alu_rd = 5'd1; s.alu_data = 32'h1; s.iss_v = 1; s.iss_rd = 5'd20;
    applyStimulus(s);
    s = lsu_s(5'd21, 32'h2121_2121, LW, 2'd0);
    s.alu_v = 1; s.alu_rd = 5'd1; s.alu_data = 32'h2; s.iss_v = 1; s.iss_rd = 5'd21;
    applyStimulus(s);
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(idle_s());
      checkOutput("post_rst_wren", 32'(o_rd_wren), 32'd0);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s.alu_v    = ($urandom_range(0, 99) < 45);
      s.alu_rd   = 5'($urandom_range(0, 31));
      s.alu_data = $urandom;
      s.lsu_v    = ($urandom_range(0, 99) < 55);
      s.lsu_rd   = 5'($urandom_range(0, 31));
      s.lsu_data = $urandom;
      s.f3       = 3'($urandom_range(0, 7));
      s.boff     = 2'($urandom_range(0, 3));
      s.iss_v    = ($urandom_range(0, 99) < 25);
      s.iss_rd   = 5'($urandom_range(0, 31));
      applyStimulus(s);
    end

    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(idle_s());
    checkOutput("end_ready", 32'(o_lsu_ready), 32'd1);
    @(negedge i_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
